tlb_unit: RTL and testbench



---
 rtl/tlb_pkg.sv | 48 ++++
 rtl/tlb_match.sv | 39 +++
 rtl/tlb_unit.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_tlb_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the joint TLB: command encodings, FSM states,
// the stored entry layout and CP0 write-enable bit positions.
package tlb_pkg;

   // Default geometry; IDX_W must equal log2(TLBNUM)
   localparam int unsigned TLBNUM_DEF = 16;
   localparam int unsigned IDX_W_DEF  = 4;

   // Command opcodes as presented on cmd_op
   localparam logic [1:0] TLB_OP_NONE = 2'b00;
   localparam logic [1:0] TLB_OP_P    = 2'b01;
   localparam logic [1:0] TLB_OP_R    = 2'b10;
   localparam logic [1:0] TLB_OP_WI   = 2'b11;

   // Bit positions inside cp0_wen
   localparam int unsigned WEN_ENTRYHI  = 3;
   localparam int unsigned WEN_ENTRYLO0 = 2;
   localparam int unsigned WEN_ENTRYLO1 = 1;
   localparam int unsigned WEN_INDEX    = 0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } tlb_state_e;

   // One dual-page TLB entry; g is the AND of the two EntryLo G bits
   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   // EntryLo image: {6'b0, pfn, c, d, v, g}
   function automatic logic [31:0] mk_entrylo(input logic [19:0] pfn, input logic [2:0] c,
                                              input logic d, input logic v, input logic g);
      return {6'b0, pfn, c, d, v, g};
   endfunction

endpackage

// File: rtl/tlb_match.sv
// Associative lookup: compares a VPN2/ASID key against every entry in parallel
// and reports the lowest-numbered matching entry.
module tlb_match
   import tlb_pkg::*;
#(
   parameter int unsigned TLBNUM = TLBNUM_DEF,
   parameter int unsigned IDX_W  = IDX_W_DEF
) (
   input  logic [TLBNUM-1:0][18:0] ent_vpn2,
   input  logic [TLBNUM-1:0][7:0]  ent_asid,
   input  logic [TLBNUM-1:0]       ent_g,
   input  logic [18:0]             key_vpn2,
   input  logic [7:0]              key_asid,
   output logic                    hit,
   output logic [IDX_W-1:0]        idx
);

   logic [TLBNUM-1:0] match;

   // Per-entry compare; global entries ignore the ASID
   always_comb begin
      match = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         match[i] = (ent_vpn2[i] == key_vpn2) && (ent_g[i] || (ent_asid[i] == key_asid));
      end
   end

   // Priority encode; scanning downward leaves the lowest matching index in idx
   always_comb begin
      hit = |match;
      idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (match[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/tlb_unit.sv
// MIPS-style joint TLB behind the CP0 TLB registers. Runs TLBWI/TLBR/TLBP through
// an IDLE->EXEC->RESP command FSM and offers one registered translation port.
// Optional macro KSEG_DIRECT_EN: kseg0/kseg1 addresses bypass the TLB.
module tlb_unit
   import tlb_pkg::*;
#(
   parameter int unsigned TLBNUM = TLBNUM_DEF,
   parameter int unsigned IDX_W  = IDX_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [18:0] vpn2,
   input  logic [7:0]  asid,
   input  logic [19:0] pfn0,
   input  logic [19:0] pfn1,
   input  logic [2:0]  c0,
   input  logic [2:0]  c1,
   input  logic        d0,
   input  logic        d1,
   input  logic        v0,
   input  logic        v1,
   input  logic        g0,
   input  logic        g1,
   input  logic [30:0] index,
   output logic        done,
   output logic [3:0]  cp0_wen,
   output logic [31:0] entryhi_wdata,
   output logic [31:0] entrylo0_wdata,
   output logic [31:0] entrylo1_wdata,
   output logic [31:0] index_wdata,
   input  logic        tr_valid,
   input  logic [31:0] tr_vaddr,
   output logic        tr_rvalid,
   output logic [31:0] tr_paddr,
   output logic        tr_miss,
   output logic        tr_invalid,
   output logic        tr_dirty,
   output logic [2:0]  tr_cattr
);

   tlb_state_e              state_q, state_d;
   logic [1:0]              op_q, op_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   tlb_entry_t              cmd_ent_q, cmd_ent_d;
   tlb_entry_t [TLBNUM-1:0] entries_q, entries_d;
   tlb_entry_t              rd_ent;

   logic        done_q, done_d;
   logic [3:0]  wen_q, wen_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo0_q, lo0_d;
   logic [31:0] lo1_q, lo1_d;
   logic [31:0] idxw_q, idxw_d;

   logic        rvalid_q, rvalid_d;
   logic [31:0] paddr_q, paddr_d;
   logic        miss_q, miss_d;
   logic        inv_q, inv_d;
   logic        dirty_q, dirty_d;
   logic [2:0]  cattr_q, cattr_d;

   logic [TLBNUM-1:0][18:0] ent_vpn2;
   logic [TLBNUM-1:0][7:0]  ent_asid;
   logic [TLBNUM-1:0]       ent_g;
   logic                    p_hit, t_hit;
   logic [IDX_W-1:0]        p_idx, t_idx;

   // Index bits above the array size are architecturally ignored
   logic unused_index;
   assign unused_index = ^index[30:IDX_W];

   // Split the tag fields out of the array for the two lookup ports
   always_comb begin
      ent_vpn2 = '0;
      ent_asid = '0;
      ent_g    = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         ent_vpn2[i] = entries_q[i].vpn2;
         ent_asid[i] = entries_q[i].asid;
         ent_g[i]    = entries_q[i].g;
      end
   end

   // TLBP lookup on the captured EntryHi
   tlb_match #(
      .TLBNUM (TLBNUM),
      .IDX_W  (IDX_W)
   ) u_match_probe (
      .ent_vpn2 (ent_vpn2),
      .ent_asid (ent_asid),
      .ent_g    (ent_g),
      .key_vpn2 (cmd_ent_q.vpn2),
      .key_asid (cmd_ent_q.asid),
      .hit      (p_hit),
      .idx      (p_idx)
   );

   // Translation lookup on the live address and current ASID
   tlb_match #(
      .TLBNUM (TLBNUM),
      .IDX_W  (IDX_W)
   ) u_match_xlate (
      .ent_vpn2 (ent_vpn2),
      .ent_asid (ent_asid),
      .ent_g    (ent_g),
      .key_vpn2 (tr_vaddr[31:13]),
      .key_asid (asid),
      .hit      (t_hit),
      .idx      (t_idx)
   );

   assign rd_ent = entries_q[idx_q];

   // Command FSM next state, operand capture and CP0 response data
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      idx_d     = idx_q;
      cmd_ent_d = cmd_ent_q;
      done_d    = 1'b0;
      wen_d     = '0;
      hi_d      = '0;
      lo0_d     = '0;
      lo1_d     = '0;
      idxw_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid && (cmd_op != TLB_OP_NONE)) begin
               op_d           = cmd_op;
               idx_d          = index[IDX_W-1:0];
               cmd_ent_d.vpn2 = vpn2;
               cmd_ent_d.asid = asid;
               cmd_ent_d.g    = g0 & g1;
               cmd_ent_d.pfn0 = pfn0;
               cmd_ent_d.c0   = c0;
               cmd_ent_d.d0   = d0;
               cmd_ent_d.v0   = v0;
               cmd_ent_d.pfn1 = pfn1;
               cmd_ent_d.c1   = c1;
               cmd_ent_d.d1   = d1;
               cmd_ent_d.v1   = v1;
               state_d        = StExec;
            end
         end
         StExec: begin
            state_d = StResp;
            done_d  = 1'b1;
            case (op_q)
               TLB_OP_P: begin
                  wen_d[WEN_INDEX] = 1'b1;
                  idxw_d           = p_hit ? 32'(p_idx) : 32'h8000_0000;
               end
               TLB_OP_R: begin
                  wen_d[WEN_ENTRYHI]  = 1'b1;
                  wen_d[WEN_ENTRYLO0] = 1'b1;
                  wen_d[WEN_ENTRYLO1] = 1'b1;
                  hi_d  = {rd_ent.vpn2, 5'b0, rd_ent.asid};
                  lo0_d = mk_entrylo(rd_ent.pfn0, rd_ent.c0, rd_ent.d0, rd_ent.v0, rd_ent.g);
                  lo1_d = mk_entrylo(rd_ent.pfn1, rd_ent.c1, rd_ent.d1, rd_ent.v1, rd_ent.g);
               end
               default: ;
            endcase
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Command FSM state and registered CP0 outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= TLB_OP_NONE;
         idx_q     <= '0;
         cmd_ent_q <= '0;
         done_q    <= 1'b0;
         wen_q     <= '0;
         hi_q      <= '0;
         lo0_q     <= '0;
         lo1_q     <= '0;
         idxw_q    <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         idx_q     <= idx_d;
         cmd_ent_q <= cmd_ent_d;
         done_q    <= done_d;
         wen_q     <= wen_d;
         hi_q      <= hi_d;
         lo0_q     <= lo0_d;
         lo1_q     <= lo1_d;
         idxw_q    <= idxw_d;
      end
   end

   // TLBWI commits on the edge leaving EXEC; a reset on that edge wins
   always_comb begin
      entries_d = entries_q;
      if ((state_q == StExec) && (op_q == TLB_OP_WI)) begin
         entries_d[idx_q] = cmd_ent_q;
      end
   end

   // Entry array storage
   always_ff @(posedge clk) begin
      if (rst) begin
         entries_q <= '0;
      end else begin
         entries_q <= entries_d;
      end
   end

   // Translation result; reads pre-write contents since entries_q is used directly
   always_comb begin
      rvalid_d = tr_valid;
      paddr_d  = '0;
      miss_d   = 1'b0;
      inv_d    = 1'b0;
      dirty_d  = 1'b0;
      cattr_d  = '0;
      if (tr_valid) begin
         if (!t_hit) begin
            miss_d = 1'b1;
         end else if (tr_vaddr[12]) begin
            paddr_d = {entries_q[t_idx].pfn1, tr_vaddr[11:0]};
            inv_d   = ~entries_q[t_idx].v1;
            dirty_d = entries_q[t_idx].d1;
            cattr_d = entries_q[t_idx].c1;
         end else begin
            paddr_d = {entries_q[t_idx].pfn0, tr_vaddr[11:0]};
            inv_d   = ~entries_q[t_idx].v0;
            dirty_d = entries_q[t_idx].d0;
            cattr_d = entries_q[t_idx].c0;
         end
`ifdef KSEG_DIRECT_EN
         // kseg0 is cached (3), kseg1 uncached (2)
         if (tr_vaddr[31:30] == 2'b10) begin
            paddr_d = {3'b0, tr_vaddr[28:0]};
            miss_d  = 1'b0;
            inv_d   = 1'b0;
            dirty_d = 1'b1;
            cattr_d = tr_vaddr[29] ? 3'd2 : 3'd3;
         end
`endif
      end
   end

   // Translation result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         paddr_q  <= '0;
         miss_q   <= 1'b0;
         inv_q    <= 1'b0;
         dirty_q  <= 1'b0;
         cattr_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         paddr_q  <= paddr_d;
         miss_q   <= miss_d;
         inv_q    <= inv_d;
         dirty_q  <= dirty_d;
         cattr_q  <= cattr_d;
      end
   end

   assign cmd_ready      = (state_q == StIdle);
   assign done           = done_q;
   assign cp0_wen        = wen_q;
   assign entryhi_wdata  = hi_q;
   assign entrylo0_wdata = lo0_q;
   assign entrylo1_wdata = lo1_q;
   assign index_wdata    = idxw_q;
   assign tr_rvalid      = rvalid_q;
   assign tr_paddr       = paddr_q;
   assign tr_miss        = miss_q;
   assign tr_invalid     = inv_q;
   assign tr_dirty       = dirty_q;
   assign tr_cattr       = cattr_q;

endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: a vector table of commands and translations,
// plus hand-written sequences for write/translate overlap, ignored ops and reset abort.
module tb_tlb_unit;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [18:0] vpn2;
   logic [7:0]  asid;
   logic [19:0] pfn0, pfn1;
   logic [2:0]  c0, c1;
   logic        d0, d1, v0, v1, g0, g1;
   logic [30:0] index;
   logic        done;
   logic [3:0]  cp0_wen;
   logic [31:0] entryhi_wdata, entrylo0_wdata, entrylo1_wdata, index_wdata;
   logic        tr_valid, tr_rvalid, tr_miss, tr_invalid, tr_dirty;
   logic [31:0] tr_vaddr, tr_paddr;
   logic [2:0]  tr_cattr;

   int checks = 0;
   int errors = 0;

   tlb_unit dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .vpn2           (vpn2),
      .asid           (asid),
      .pfn0           (pfn0),
      .pfn1           (pfn1),
      .c0             (c0),
      .c1             (c1),
      .d0             (d0),
      .d1             (d1),
      .v0             (v0),
      .v1             (v1),
      .g0             (g0),
      .g1             (g1),
      .index          (index),
      .done           (done),
      .cp0_wen        (cp0_wen),
      .entryhi_wdata  (entryhi_wdata),
      .entrylo0_wdata (entrylo0_wdata),
      .entrylo1_wdata (entrylo1_wdata),
      .index_wdata    (index_wdata),
      .tr_valid       (tr_valid),
      .tr_vaddr       (tr_vaddr),
      .tr_rvalid      (tr_rvalid),
      .tr_paddr       (tr_paddr),
      .tr_miss        (tr_miss),
      .tr_invalid     (tr_invalid),
      .tr_dirty       (tr_dirty),
      .tr_cattr       (tr_cattr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          is_tr;
      logic [1:0]  op;
      logic [3:0]  idx;
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic [19:0] pfn0, pfn1;
      logic [2:0]  c0, c1;
      logic        d0, d1, v0, v1, g0, g1;
      logic [31:0] vaddr;
      logic [3:0]  e_wen;
      logic [31:0] e_idx, e_hi, e_lo0, e_lo1;
      logic        e_miss, e_inv, e_dirty;
      logic [2:0]  e_cattr;
      logic [31:0] e_paddr;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] lo(input logic [19:0] p, input logic [2:0] c,
                                      input logic d, input logic v, input logic g);
      return {6'b0, p, c, d, v, g};
   endfunction

   function automatic vec_t blank();
      vec_t v;
      v = '{is_tr: 1'b0, op: 2'b00, idx: 4'd0, vpn2: '0, asid: '0, pfn0: '0, pfn1: '0,
            c0: '0, c1: '0, d0: 1'b0, d1: 1'b0, v0: 1'b0, v1: 1'b0, g0: 1'b0, g1: 1'b0,
            vaddr: '0, e_wen: '0, e_idx: '0, e_hi: '0, e_lo0: '0, e_lo1: '0,
            e_miss: 1'b0, e_inv: 1'b0, e_dirty: 1'b0, e_cattr: '0, e_paddr: '0};
      return v;
   endfunction

   function automatic vec_t mk_wi(input logic [3:0] i, input logic [18:0] vp, input logic [7:0] as,
                                  input logic [19:0] p0, input logic [2:0] cc0, input logic dd0,
                                  input logic vv0, input logic [19:0] p1, input logic [2:0] cc1,
                                  input logic dd1, input logic vv1, input logic gg0,
                                  input logic gg1);
      vec_t v = blank();
      v.op = 2'b11; v.idx = i; v.vpn2 = vp; v.asid = as;
      v.pfn0 = p0; v.c0 = cc0; v.d0 = dd0; v.v0 = vv0;
      v.pfn1 = p1; v.c1 = cc1; v.d1 = dd1; v.v1 = vv1;
      v.g0 = gg0; v.g1 = gg1; v.e_wen = 4'b0000;
      return v;
   endfunction

   function automatic vec_t mk_p(input logic [18:0] vp, input logic [7:0] as, input logic [31:0] ei);
      vec_t v = blank();
      v.op = 2'b01; v.vpn2 = vp; v.asid = as; v.e_wen = 4'b0001; v.e_idx = ei;
      return v;
   endfunction

   function automatic vec_t mk_r(input logic [3:0] i, input logic [31:0] hi, input logic [31:0] l0,
                                 input logic [31:0] l1);
      vec_t v = blank();
      v.op = 2'b10; v.idx = i; v.e_wen = 4'b1110; v.e_hi = hi; v.e_lo0 = l0; v.e_lo1 = l1;
      return v;
   endfunction

   function automatic vec_t mk_tr(input logic [31:0] va, input logic [7:0] as, input logic m,
                                  input logic iv, input logic dt, input logic [2:0] ca,
                                  input logic [31:0] pa);
      vec_t v = blank();
      v.is_tr = 1'b1; v.vaddr = va; v.asid = as;
      v.e_miss = m; v.e_inv = iv; v.e_dirty = dt; v.e_cattr = ca; v.e_paddr = pa;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive_cmd(input vec_t v);
      cmd_op = v.op; vpn2 = v.vpn2; asid = v.asid;
      pfn0 = v.pfn0; c0 = v.c0; d0 = v.d0; v0 = v.v0;
      pfn1 = v.pfn1; c1 = v.c1; d1 = v.d1; v1 = v.v1;
      g0 = v.g0; g1 = v.g1;
      index = {27'h7ff_0000, v.idx};  // junk in ignored upper bits
      cmd_valid = 1'b1;
   endtask

   task automatic do_cmd(input vec_t v, input string tag);
      int n;
      drive_cmd(v);
      step();
      cmd_valid = 1'b0;
      cmd_op = 2'b00;
      chk({tag, "_exec_ready"}, 32'(cmd_ready), 32'd0);
      n = 0;
      while (done !== 1'b1 && n < 4) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd1);
      chk({tag, "_wen"}, 32'(cp0_wen), 32'(v.e_wen));
      if (v.op == 2'b01) chk({tag, "_index_wdata"}, index_wdata, v.e_idx);
      if (v.op == 2'b10) begin
         chk({tag, "_entryhi"}, entryhi_wdata, v.e_hi);
         chk({tag, "_entrylo0"}, entrylo0_wdata, v.e_lo0);
         chk({tag, "_entrylo1"}, entrylo1_wdata, v.e_lo1);
      end
      step();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_wen_after"}, 32'(cp0_wen), 32'd0);
      chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
   endtask

   task automatic do_tr(input vec_t v, input string tag);
      tr_valid = 1'b1; tr_vaddr = v.vaddr; asid = v.asid;
      step();
      tr_valid = 1'b0;
      chk({tag, "_rvalid"}, 32'(tr_rvalid), 32'd1);
      chk({tag, "_miss"}, 32'(tr_miss), 32'(v.e_miss));
      chk({tag, "_invalid"}, 32'(tr_invalid), 32'(v.e_inv));
      chk({tag, "_dirty"}, 32'(tr_dirty), 32'(v.e_dirty));
      chk({tag, "_cattr"}, 32'(tr_cattr), 32'(v.e_cattr));
      chk({tag, "_paddr"}, tr_paddr, v.e_paddr);
      step();
      chk({tag, "_rvalid_drop"}, 32'(tr_rvalid), 32'd0);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; vpn2 = '0; asid = '0;
      pfn0 = '0; pfn1 = '0; c0 = '0; c1 = '0; d0 = 0; d1 = 0; v0 = 0; v1 = 0; g0 = 0; g1 = 0;
      index = '0; tr_valid = 1'b0; tr_vaddr = '0;

      // Vector table
      vecs.push_back(mk_tr(32'h0040_1000, 8'd0, 1, 0, 0, 3'd0, 32'h0));
      vecs.push_back(mk_wi(4'd3, 19'h00200, 8'd5, 20'h12345, 3'd3, 1, 1, 20'h0, 3'd0, 0, 0, 0, 0));
      vecs.push_back(mk_p(19'h00200, 8'd5, 32'h0000_0003));
      vecs.push_back(mk_p(19'h00200, 8'd6, 32'h8000_0000));
      vecs.push_back(mk_tr(32'h0040_0ABC, 8'd5, 0, 0, 1, 3'd3, 32'h1234_5ABC));
      vecs.push_back(mk_tr(32'h0040_1ABC, 8'd5, 0, 1, 0, 3'd0, 32'h0000_0ABC));
      vecs.push_back(mk_tr(32'h0040_0ABC, 8'd6, 1, 0, 0, 3'd0, 32'h0));
      vecs.push_back(mk_r(4'd3, 32'h0040_0005, lo(20'h12345, 3'd3, 1, 1, 0), 32'h0));
      vecs.push_back(mk_wi(4'd7, 19'h1ABCD, 8'h11, 20'h00AAA, 3'd2, 0, 1, 20'h00BBB, 3'd5, 1, 1, 1, 1));
      vecs.push_back(mk_wi(4'd2, 19'h1ABCD, 8'h09, 20'h00CCC, 3'd4, 0, 1, 20'h0, 3'd0, 0, 0, 1, 1));
      vecs.push_back(mk_p(19'h1ABCD, 8'h77, 32'h0000_0002));
      vecs.push_back(mk_tr(32'h3579_A123, 8'h42, 0, 0, 0, 3'd4, 32'h00CC_C123));
      vecs.push_back(mk_r(4'd7, 32'h3579_A011, lo(20'h00AAA, 3'd2, 0, 1, 1),
                          lo(20'h00BBB, 3'd5, 1, 1, 1)));
      // g0 without g1 is not global
      vecs.push_back(mk_wi(4'd5, 19'h00300, 8'd1, 20'h00001, 3'd0, 0, 1, 20'h0, 3'd0, 0, 0, 1, 0));
      vecs.push_back(mk_p(19'h00300, 8'd2, 32'h8000_0000));
      vecs.push_back(mk_p(19'h00300, 8'd1, 32'h0000_0005));
`ifdef KSEG_DIRECT_EN
      vecs.push_back(mk_tr(32'hA000_1234, 8'd0, 0, 0, 1, 3'd2, 32'h0000_1234));
      vecs.push_back(mk_tr(32'h8000_5678, 8'd0, 0, 0, 1, 3'd3, 32'h0000_5678));
`else
      vecs.push_back(mk_tr(32'hA000_1234, 8'd0, 1, 0, 0, 3'd0, 32'h0));
`endif

      // Reset state
      step();
      step();
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_wen", 32'(cp0_wen), 32'd0);
      chk("rst_index_wdata", index_wdata, 32'd0);
      chk("rst_entryhi", entryhi_wdata, 32'd0);
      chk("rst_rvalid", 32'(tr_rvalid), 32'd0);
      chk("rst_miss", 32'(tr_miss), 32'd0);
      chk("rst_paddr", tr_paddr, 32'd0);
      rst = 1'b0;
      step();
      chk("rst_ready", 32'(cmd_ready), 32'd1);

      foreach (vecs[i]) begin
         if (vecs[i].is_tr) do_tr(vecs[i], $sformatf("v%0d_tr", i));
         else do_cmd(vecs[i], $sformatf("v%0d_cmd", i));
      end

      // op=00 with cmd_valid is ignored
      v = blank();
      drive_cmd(v);
      step();
      cmd_valid = 1'b0;
      chk("nop_ready", 32'(cmd_ready), 32'd1);
      step();
      chk("nop_done", 32'(done), 32'd0);

      // Translation at the TLBWI write edge sees the old entry
      v = mk_wi(4'd6, 19'h00400, 8'd5, 20'h55555, 3'd1, 0, 1, 20'h0, 3'd0, 0, 0, 0, 0);
      drive_cmd(v);
      step();
      cmd_valid = 1'b0;
      tr_valid = 1'b1; tr_vaddr = 32'h0080_0123; asid = 8'd5;
      step();
      tr_valid = 1'b0;
      chk("ovl_done", 32'(done), 32'd1);
      chk("ovl_rvalid", 32'(tr_rvalid), 32'd1);
      chk("ovl_old_miss", 32'(tr_miss), 32'd1);
      tr_valid = 1'b1;
      step();
      tr_valid = 1'b0;
      chk("ovl_new_miss", 32'(tr_miss), 32'd0);
      chk("ovl_new_paddr", tr_paddr, 32'h5555_5123);
      step();

      // Reset during EXEC of a TLBWI aborts it
      v = mk_wi(4'd4, 19'h00500, 8'd0, 20'h77777, 3'd3, 1, 1, 20'h0, 3'd0, 0, 0, 0, 0);
      drive_cmd(v);
      step();
      cmd_valid = 1'b0;
      chk("abort_in_exec", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      step();
      chk("abort_done_late", 32'(done), 32'd0);
      chk("abort_wen_late", 32'(cp0_wen), 32'd0);
      do_cmd(mk_r(4'd4, 32'h0, 32'h0, 32'h0), "abort_r4");
      do_cmd(mk_r(4'd3, 32'h0, 32'h0, 32'h0), "abort_r3");
      do_cmd(mk_p(19'h00500, 8'd0, 32'h8000_0000), "abort_p");
      do_tr(mk_tr(32'h0080_0123, 8'd5, 1, 0, 0, 3'd0, 32'h0), "abort_tr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
